// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and coordinate type, also used by the graphics path.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;

    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    typedef logic [CNT_W-1:0] coord_t;

    function automatic int unsigned line_total(input int unsigned disp, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return disp + front + sync + back;
    endfunction

    localparam int unsigned H_TOTAL = line_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int unsigned V_TOTAL = line_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-coordinate / sync bundle from the timing generator to the RGB path.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   p_tick;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   frame_tick;

    modport master (
        output p_tick,
        output pixel_x,
        output pixel_y,
        output video_on,
        output hsync,
        output vsync,
        output frame_tick
    );

    modport slave (
        input p_tick,
        input pixel_x,
        input pixel_y,
        input video_on,
        input hsync,
        input vsync,
        input frame_tick
    );

endinterface

// File: rtl/mod_m_counter.sv
// Enabled modulo-M counter; exposes its next value so callers can register decodes with zero skew.
module mod_m_counter #(
    parameter int unsigned M     = 4,
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [Width-1:0] count_o,
    output logic [Width-1:0] count_next_o,
    output logic             wrap_o
);

    localparam logic [Width-1:0] Last = Width'(M - 1);

    if (M < 1 || M > (1 << Width)) begin : g_bad_m
        $error("mod_m_counter: M does not fit in Width bits");
    end

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    // Terminal count, not gated by the enable.
    assign wrap_o = (count_q == Last);

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = wrap_o ? '0 : count_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, h/v counters, registered syncs and frame strobe.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    localparam int unsigned H_TOTAL_P = line_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL_P = line_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam coord_t HDisp   = coord_t'(H_DISPLAY);
    localparam coord_t VDisp   = coord_t'(V_DISPLAY);
    localparam coord_t HsFirst = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HsLast  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VsFirst = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VsLast  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end
    if (H_TOTAL_P > 1024) begin : g_bad_h
        $error("vga_sync_gen: horizontal total exceeds 1024");
    end
    if (V_TOTAL_P > 1024) begin : g_bad_v
        $error("vga_sync_gen: vertical total exceeds 1024");
    end

    logic [DivW-1:0] div_cnt;
    logic [DivW-1:0] div_cnt_next;
    logic            p_tick;
    logic            h_wrap;
    logic            v_wrap;
    coord_t          h_cnt;
    coord_t          h_cnt_next;
    coord_t          v_cnt;
    coord_t          v_cnt_next;

    logic hsync_q;
    logic hsync_d;
    logic vsync_q;
    logic vsync_d;

    mod_m_counter #(
        .M     (CLK_DIV),
        .Width (DivW)
    ) u_div (
        .clk          (clk),
        .reset        (reset),
        .en_i         (1'b1),
        .count_o      (div_cnt),
        .count_next_o (div_cnt_next),
        .wrap_o       (p_tick)
    );

    mod_m_counter #(
        .M     (H_TOTAL_P),
        .Width (CNT_W)
    ) u_h (
        .clk          (clk),
        .reset        (reset),
        .en_i         (p_tick),
        .count_o      (h_cnt),
        .count_next_o (h_cnt_next),
        .wrap_o       (h_wrap)
    );

    mod_m_counter #(
        .M     (V_TOTAL_P),
        .Width (CNT_W)
    ) u_v (
        .clk          (clk),
        .reset        (reset),
        .en_i         (p_tick & h_wrap),
        .count_o      (v_cnt),
        .count_next_o (v_cnt_next),
        .wrap_o       (v_wrap)
    );

    // The divider state is only needed through its wrap strobe.
    logic unused_div;
    assign unused_div = ^{div_cnt, div_cnt_next};

    // Decode from next-state counters so the registered syncs move on the same edge as pixel_x/y.
    always_comb begin
        hsync_d = ~SYNC_POL;
        vsync_d = ~SYNC_POL;
        if (h_cnt_next >= HsFirst && h_cnt_next <= HsLast) begin
            hsync_d = SYNC_POL;
        end
        if (v_cnt_next >= VsFirst && v_cnt_next <= VsLast) begin
            vsync_d = SYNC_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vga.p_tick     = p_tick;
    assign vga.pixel_x    = h_cnt;
    assign vga.pixel_y    = v_cnt;
    assign vga.video_on   = (h_cnt < HDisp) && (v_cnt < VDisp);
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.frame_tick = p_tick & h_wrap & v_wrap;

endmodule
